// File: rtl/noise_sched_pkg.sv
// Shared types and constants for the noise frame scheduler.
package noise_sched_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int DW_DEF     = 16;
  localparam int CH_W       = $clog2(NUM_CH_DEF);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    CAPTURE,
    STREAM
  } state_t;

  // Returns tap k (DW_DEF bits) from a flat tap bus, tap 0 in the LSBs.
  function automatic logic [DW_DEF-1:0] tap_slice(
    input logic [NUM_CH_DEF*DW_DEF-1:0] bus,
    input int unsigned                  k
  );
    return bus[k*DW_DEF +: DW_DEF];
  endfunction

endpackage

// File: rtl/noise_frame_buf.sv
// Frame capture buffer: snapshots all taps with the channel mask applied,
// and presents the entry selected by the stream index.
module noise_frame_buf
  import noise_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DW     = DW_DEF,
  parameter int CW     = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_en,
  input  logic [NUM_CH-1:0]    cap_mask,
  input  logic [NUM_CH*DW-1:0] tap_bus,
  input  logic [CW-1:0]        rd_idx,
  output logic [DW-1:0]        rd_data
);

  logic [DW-1:0] mem_q [NUM_CH];

  // Capture register array; masked channels are stored as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this small register array is cleared on reset so out_data reads
      // zero after reset; a large RAM would normally be left unreset.
      for (int k = 0; k < NUM_CH; k++) mem_q[k] <= '0;
    end else if (cap_en) begin
      for (int k = 0; k < NUM_CH; k++)
        mem_q[k] <= cap_mask[k] ? tap_slice(tap_bus, k) : '0;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/noise_frame_scheduler.sv
// Per-frame sequencer for the shared noise LFSR: step burst, settle,
// tap capture, then one masked sample per channel over valid/ready.
module noise_frame_scheduler
  import noise_sched_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DW         = DW_DEF,
  parameter int SETTLE_CYC = 1,
  localparam int CW        = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic [2:0]           steps_cfg,
  input  logic [NUM_CH-1:0]    chan_mask,
  input  logic [NUM_CH*DW-1:0] tap_bus,
  output logic                 lfsr_step,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;      // remaining step pulses minus 1
  logic [SW-1:0]     settle_q, settle_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              cap_en;
  logic              last_beat;
  logic              frame_done_q;
  logic              overrun_q;

  // Next-state logic and per-frame counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    cap_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          step_d  = steps_cfg;
          mask_d  = chan_mask;
          state_d = STEP;
        end
      end
      STEP: begin
        settle_d = '0;
        if (step_q == 3'd0) state_d = SETTLE;
        else                step_d  = step_q - 3'd1;
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d  = CAPTURE;
        else                                 settle_d = settle_q + SW'(1);
      end
      CAPTURE: begin
        cap_en  = 1'b1;
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == CW'(NUM_CH - 1)) state_d = IDLE;
          else                          idx_d   = idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_beat = (state_q == STREAM) && out_ready && (idx_q == CW'(NUM_CH - 1));

  // State register, frame-end pulse and sticky overrun flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      settle_q     <= '0;
      idx_q        <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      settle_q     <= settle_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      frame_done_q <= last_beat;
      // A new overrun event takes priority over a simultaneous clear.
      if (sample_tick && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (overrun_clr)                 overrun_q <= 1'b0;
    end
  end

  noise_frame_buf #(
    .NUM_CH (NUM_CH),
    .DW     (DW),
    .CW     (CW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .cap_mask (mask_q),
    .tap_bus  (tap_bus),
    .rd_idx   (idx_q),
    .rd_data  (out_data)
  );

  assign lfsr_step  = (state_q == STEP);
  assign out_valid  = (state_q == STREAM);
  assign out_chan   = idx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/noise_frame_scheduler.md
Name: noise_frame_scheduler

Overview:
- Sequences the shared 8-tap noise LFSR once per audio sample frame.
- Issues a programmable burst of LFSR step enables on each sample tick, which sets noise velocity/brightness.
- After the burst settles, it snapshots all 8 taps and streams them as one serial sample stream over valid/ready, one channel per beat, applying a per-channel mute mask.
- Sits between the sample-rate tick generator and the downstream voice mixer.

Parameters:
- NUM_CH, 8, number of LFSR taps/channels per frame (channel index width = clog2(NUM_CH)).
- DW, 16, signed sample width per tap.
- SETTLE_CYC, 1, idle cycles between the last step pulse and tap capture (min 1).

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle frame-start strobe.
- steps_cfg  in  3  LFSR steps per frame minus 1 (0 → 1 step, 7 → 8 steps).
- chan_mask  in  NUM_CH  bit k=1 enables channel k; 0 forces its sample to zero.
- tap_bus  in  NUM_CH*DW  tap k at bits [DW*k+DW-1 : DW*k], signed.
- lfsr_step  out  1  clock-enable pulse to the LFSR; one LFSR shift per high cycle.
- out_data  out  DW  signed sample for channel out_chan.
- out_chan  out  clog2(NUM_CH)  channel index of the current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- frame_done  out  1  one-cycle pulse the cycle after channel NUM_CH-1 is accepted.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky flag: a tick arrived while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values: lfsr_step=0, out_valid=0, out_data=0, out_chan=0, frame_done=0, busy=0, overrun=0, state=IDLE, capture buffer=0.
- Reset asserted mid-frame aborts immediately. At the next edge, lfsr_step and out_valid drop, the partial frame is discarded and no frame_done is issued.
- FSM states: IDLE, STEP, SETTLE, CAPTURE, STREAM.
- IDLE: on sample_tick, latch N = steps_cfg+1 and chan_mask into frame registers, then go to STEP. Config changes mid-frame have no effect until the next frame.
- STEP: lfsr_step=1 for exactly N consecutive cycles, counted by a down-counter, then go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles with lfsr_step=0, then go to CAPTURE.
- CAPTURE: one cycle. Register all NUM_CH taps into the buffer, with masked channels written as 0. Set chan index to 0, then go to STREAM.
- STREAM: out_valid=1, out_chan = index, out_data = buffer[index].
  - On out_valid && out_ready: if index=NUM_CH-1, go to IDLE and pulse frame_done next cycle; otherwise increment index.
- Latency: tick sampled at edge E → lfsr_step high for cycles E+1..E+N → first out_valid at E+N+SETTLE_CYC+2. The minimum frame is NUM_CH beats with out_ready held high.
- Handshake rules:
  - out_data and out_chan are held stable while out_valid && !out_ready.
  - out_valid never drops without acceptance, except on reset.
  - No combinational path from out_ready to out_valid.
- Overrun:
  - sample_tick in any non-IDLE state is dropped, sets overrun, and does not restart or extend the frame.
  - A tick on the same cycle as the STREAM→IDLE transition is also dropped and flagged.
  - Simultaneous overrun_clr and a new overrun event: the set wins.
- Width rules: masking substitutes zero. Data passes through unmodified, with no arithmetic on samples.
- Channel index wraps only via the frame end, never modulo within a frame.

Decomposition:
- Package noise_sched_pkg holds:
  - the state enum (IDLE, STEP, SETTLE, CAPTURE, STREAM);
  - NUM_CH_DEF=8 and DW_DEF=16;
  - the CH_W = clog2(NUM_CH) constant;
  - a tap-slice function returning tap k from a flat bus.
- One sub-module, noise_frame_buf: capture register array with mask-on-write plus the index-selected output mux.
- The FSM, step counter, settle counter and overrun flag stay in the top module.

Test Plan:
- steps_cfg=0, mask=8'hFF, SETTLE_CYC=1, out_ready=1, tick at edge E → lfsr_step high only in cycle E+1; out_valid from E+4; chans 0..7 on 8 consecutive beats; frame_done one cycle after chan 7; busy low after.
- steps_cfg=7 → exactly 8 lfsr_step cycles; tap_bus driven k→16'h1000+k at capture → beats carry 16'h1000..16'h1007 in order.
- chan_mask=8'b1010_0101 with taps all 16'h7FFF → chans 1,3,4,6 output 0x0000 and the rest 0x7FFF; steps_cfg/mask changed mid-frame → current frame unaffected.
- out_ready toggled 1,0,0,1 during STREAM → out_data/out_chan held during stalls; no beat lost or duplicated; 8 beats total.
- Second tick during STREAM → overrun=1, frame unchanged; overrun_clr alone → overrun=0; overrun_clr plus an overrunning tick in the same cycle → overrun stays 1.
- reset asserted at beat 3 of STREAM → next cycle all outputs at reset values, no frame_done; a tick after reset release starts a clean frame from chan 0.
